// File: rtl/bram_b_arbiter_pkg.sv
// Shared types for the BRAM port-B burst arbiter.
//   arb_state_e : arbiter FSM state
//   req_id_t    : requester identifier (0 = datapath, 1 = MMIO read path)
//   ret_tag_t   : per-beat tag carried alongside the BRAM read latency
//   BEAT_BYTES  : beat stride for the default 64-bit word; beat_bytes() for other widths
package bram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StDrain
    } arb_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned BEAT_BYTES         = DEFAULT_DATA_WIDTH / 8;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
        logic    last;
    } ret_tag_t;

    function automatic int unsigned beat_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/bram_b_arbiter_if.sv
// Bundle of requester handshakes and BRAM port-B pins around the arbiter.
//   slave  : the arbiter (consumes requests and bram_doutb, drives grants/returns/BRAM pins)
//   master : the requesters and the BRAM model/pins on the other side
interface bram_b_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64
);
    logic                    r0_req;
    logic                    r1_req;
    logic [ADDR_WIDTH-1:0]   r0_addr;
    logic [ADDR_WIDTH-1:0]   r1_addr;
    logic [3:0]              r0_len;
    logic [3:0]              r1_len;
    logic                    r0_gnt;
    logic                    r1_gnt;
    logic                    r0_rvalid;
    logic                    r1_rvalid;
    logic                    r0_rlast;
    logic                    r1_rlast;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDR_WIDTH-1:0]   bram_addrb;
    logic                    bram_enb;
    logic [DATA_WIDTH-1:0]   bram_doutb;
    logic [DATA_WIDTH-1:0]   bram_dinb;
    logic [DATA_WIDTH/8-1:0] bram_web;

    modport slave (
        input  r0_req, r1_req, r0_addr, r1_addr, r0_len, r1_len, bram_doutb,
        output r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rlast, r1_rlast, rdata,
               bram_addrb, bram_enb, bram_dinb, bram_web
    );

    modport master (
        output r0_req, r1_req, r0_addr, r1_addr, r0_len, r1_len, bram_doutb,
        input  r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rlast, r1_rlast, rdata,
               bram_addrb, bram_enb, bram_dinb, bram_web
    );

endinterface

// File: rtl/bram_b_arbiter_rd_return_pipe.sv
// Delay line for per-beat return tags, matched to the BRAM read latency.
//   clk   : clock
//   rst_n : asynchronous active-low clear (drops any in-flight beats)
//   tag_i : tag of the beat issued to the BRAM this cycle
//   tag_o : tag of the beat whose data is on bram_doutb this cycle
module rd_return_pipe
    import bram_arb_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  ret_tag_t tag_i,
    output ret_tag_t tag_o
);

    ret_tag_t stage_q [Depth];
    ret_tag_t stage_d [Depth];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < int'(Depth); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/bram_b_arbiter.sv
// Round-robin burst arbiter for the shared BRAM read port B.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : requester 0/1 handshakes (req/addr/len -> gnt/rvalid/rlast, shared rdata)
//           and BRAM port-B pins (addrb/enb/doutb/dinb/web)
//   busy  : high whenever a burst is issuing or draining
// Whole bursts are granted; beats issue one per cycle and the owner tag travels through a
// RD_LATENCY-deep pipe so rvalid lines up with bram_doutb.
module bram_b_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            reset,
    bram_b_arbiter_if.slave bus,
    output logic            busy
);

    localparam int unsigned          BeatBytes = beat_bytes(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(BeatBytes - 1);
    localparam logic [ADDR_WIDTH-1:0] Stride    = ADDR_WIDTH'(BeatBytes);
    localparam logic [2:0]            DrainLast = 3'(RD_LATENCY - 1);

    arb_state_e            state_q, state_d;
    req_id_t               ptr_q, ptr_d;
    req_id_t               owner_q, owner_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            beat_q, beat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            drain_q, drain_d;
    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    req_id_t               win;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        len_d   = len_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        win     = ptr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.r0_req || bus.r1_req) begin
                    // A lone requester wins; the pointer only breaks ties.
                    if (bus.r0_req && bus.r1_req) begin
                        win = ptr_q;
                    end else begin
                        win = bus.r1_req;
                    end
                    state_d = StBurst;
                    owner_d = win;
                    len_d   = win ? bus.r1_len : bus.r0_len;
                    addr_d  = (win ? bus.r1_addr : bus.r0_addr) & AlignMask;
                    beat_d  = 4'd0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            StBurst: begin
                if (beat_q == len_q) begin
                    state_d = StDrain;
                    drain_d = 3'd0;
                end else begin
                    beat_d = beat_q + 4'd1;
                    addr_d = addr_q + Stride;  // wraps modulo 2^ADDR_WIDTH
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StIdle;
                    ptr_d   = ~owner_q;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            len_q   <= 4'd0;
            beat_q  <= 4'd0;
            addr_q  <= '0;
            drain_q <= 3'd0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
        end
    end

    ret_tag_t tag_in;
    ret_tag_t tag_out;

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (state_q == StBurst);
        tag_in.owner = owner_q;
        tag_in.last  = (beat_q == len_q);
    end

    rd_return_pipe #(
        .Depth (RD_LATENCY)
    ) u_rd_return_pipe (
        .clk   (clk),
        .rst_n (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign bus.r0_gnt     = gnt0_q;
    assign bus.r1_gnt     = gnt1_q;
    assign bus.bram_enb   = (state_q == StBurst);
    assign bus.bram_addrb = addr_q;
    assign bus.bram_dinb  = '0;
    assign bus.bram_web   = '0;

    assign bus.r0_rvalid = tag_out.valid & ~tag_out.owner;
    assign bus.r1_rvalid = tag_out.valid & tag_out.owner;
    assign bus.r0_rlast  = bus.r0_rvalid & tag_out.last;
    assign bus.r1_rlast  = bus.r1_rvalid & tag_out.last;
    // Gated so rdata reads 0 out of reset and between returned beats.
    assign bus.rdata     = tag_out.valid ? bus.bram_doutb : '0;

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_bram_b_arbiter.sv
// Bench for bram_b_arbiter: two instances (RD_LATENCY 1 and 3) share stimulus, one selected at
// a time. Expected outputs come from a schedule model keyed by cycle number.
module tb_bram_b_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          sel;
    logic          r0_req, r1_req;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [3:0]    r0_len, r1_len;
    logic          busy1, busy3;

    bram_b_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();
    bram_b_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if3 ();

    bram_b_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if1),
        .busy  (busy1)
    );

    bram_b_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if3),
        .busy  (busy3)
    );

    assign if1.r0_req  = r0_req & ~sel;
    assign if1.r1_req  = r1_req & ~sel;
    assign if3.r0_req  = r0_req & sel;
    assign if3.r1_req  = r1_req & sel;
    assign if1.r0_addr = r0_addr;
    assign if1.r1_addr = r1_addr;
    assign if3.r0_addr = r0_addr;
    assign if3.r1_addr = r1_addr;
    assign if1.r0_len  = r0_len;
    assign if1.r1_len  = r1_len;
    assign if3.r0_len  = r0_len;
    assign if3.r1_len  = r1_len;

    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_C3C3, ~a + 32'd7};
    endfunction

    // BRAM models: requested word after the instance's latency, junk when not enabled.
    logic [DW-1:0] b1_q;
    logic [DW-1:0] b3_q [3];
    always @(posedge clk) begin
        b1_q    <= if1.bram_enb ? word(if1.bram_addrb) : {$urandom, $urandom};
        b3_q[0] <= if3.bram_enb ? word(if3.bram_addrb) : {$urandom, $urandom};
        b3_q[1] <= b3_q[0];
        b3_q[2] <= b3_q[1];
    end
    assign if1.bram_doutb = b1_q;
    assign if3.bram_doutb = b3_q[2];

    // Observed flags: {gnt0, gnt1, enb, rvalid0, rvalid1, rlast0, rlast1}
    logic [6:0]    obs_flags;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_data;
    logic          obs_busy;
    logic          obs_tie;
    assign obs_flags = sel ?
        {if3.r0_gnt, if3.r1_gnt, if3.bram_enb, if3.r0_rvalid, if3.r1_rvalid, if3.r0_rlast,
         if3.r1_rlast} :
        {if1.r0_gnt, if1.r1_gnt, if1.bram_enb, if1.r0_rvalid, if1.r1_rvalid, if1.r0_rlast,
         if1.r1_rlast};
    assign obs_addr = sel ? if3.bram_addrb : if1.bram_addrb;
    assign obs_data = sel ? if3.rdata : if1.rdata;
    assign obs_busy = sel ? busy3 : busy1;
    assign obs_tie  = sel ? |{if3.bram_dinb, if3.bram_web} : |{if1.bram_dinb, if1.bram_web};

    // Reference model state
    int unsigned   total = 0;
    int unsigned   bad = 0;
    int            cyc = 0;
    int            next_edge = 0;
    int            busy_lo = 0;
    int            busy_hi = -1;
    logic          ptr_m [2];
    bit            drop0, drop1;
    logic [6:0]    exp_flags [int];
    logic [AW-1:0] exp_addr [int];
    logic [DW-1:0] exp_dat [int];

    logic [31:0]   addr_log [$];
    logic [31:0]   gnt_log [$];
    logic [31:0]   want_q [$];
    int            rv_count;

    function automatic void add_flag(input int c, input logic [6:0] f);
        if (exp_flags.exists(c)) exp_flags[c] = exp_flags[c] | f;
        else exp_flags[c] = f;
    endfunction

    // Called at each rising edge with the request inputs the DUT is sampling.
    task automatic model_edge();
        int            w;
        int            lat;
        int            len;
        logic [AW-1:0] base;
        logic [AW-1:0] a;
        cyc++;
        if (!rst_n) return;
        if (cyc < next_edge || !(r0_req || r1_req)) return;
        if (r0_req && r1_req) w = int'(ptr_m[sel]);
        else w = r1_req ? 1 : 0;
        lat  = sel ? 3 : 1;
        len  = w ? int'(r1_len) : int'(r0_len);
        base = (w ? r1_addr : r0_addr) & ~AW'(7);
        add_flag(cyc, w ? 7'b0100000 : 7'b1000000);
        for (int k = 0; k <= len; k++) begin
            a = base + AW'(8 * k);
            add_flag(cyc + k, 7'b0010000);
            exp_addr[cyc + k] = a;
            if (w == 1) add_flag(cyc + k + lat, (k == len) ? 7'b0000101 : 7'b0000100);
            else add_flag(cyc + k + lat, (k == len) ? 7'b0001010 : 7'b0001000);
            exp_dat[cyc + k + lat] = word(a);
        end
        busy_lo   = cyc;
        busy_hi   = cyc + len + lat;
        next_edge = cyc + len + lat + 2;
        ptr_m[sel] = (w == 0);
        if (w == 0) drop0 = 1'b1;
        else drop1 = 1'b1;
    endtask

    task automatic check();
        logic [6:0]    ef;
        logic          eb;
        logic [DW-1:0] ed;
        ef = exp_flags.exists(cyc) ? exp_flags[cyc] : 7'b0;
        eb = rst_n && (cyc >= busy_lo) && (cyc <= busy_hi);
        ed = exp_dat.exists(cyc) ? exp_dat[cyc] : '0;
        total++;
        assert (obs_flags === ef) else begin
            bad++;
            $error("FAIL flags cyc=%0d got=%b want=%b", cyc, obs_flags, ef);
        end
        total++;
        assert (obs_busy === eb) else begin
            bad++;
            $error("FAIL busy cyc=%0d got=%b want=%b", cyc, obs_busy, eb);
        end
        total++;
        assert (obs_data === ed) else begin
            bad++;
            $error("FAIL rdata cyc=%0d got=%h want=%h", cyc, obs_data, ed);
        end
        total++;
        assert (obs_tie === 1'b0) else begin
            bad++;
            $error("FAIL tie_off cyc=%0d got=%b want=0", cyc, obs_tie);
        end
        if (ef[4]) begin
            total++;
            assert (obs_addr === exp_addr[cyc]) else begin
                bad++;
                $error("FAIL addrb cyc=%0d got=%h want=%h", cyc, obs_addr, exp_addr[cyc]);
            end
        end
        if (obs_flags[4] === 1'b1) addr_log.push_back(obs_addr);
        if (obs_flags[6] === 1'b1) gnt_log.push_back(32'd0);
        if (obs_flags[5] === 1'b1) gnt_log.push_back(32'd1);
        if ((obs_flags[3] | obs_flags[2]) === 1'b1) rv_count++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (drop0) begin r0_req = 1'b0; drop0 = 1'b0; end
        if (drop1) begin r1_req = 1'b0; drop1 = 1'b0; end
        @(negedge clk);
        check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted mid-cycle: outputs must clear at once, not at the next edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        exp_flags.delete();
        exp_addr.delete();
        exp_dat.delete();
        busy_hi   = -1;
        next_edge = 0;
        ptr_m[0]  = 1'b0;
        ptr_m[1]  = 1'b0;
        r0_req    = 1'b0;
        r1_req    = 1'b0;
        drop0     = 1'b0;
        drop1     = 1'b0;
        #1;
        check();
        total++;
        assert (obs_addr === '0) else begin
            bad++;
            $error("FAIL reset_addrb got=%h want=0", obs_addr);
        end
        step();
        rst_n = 1'b1;
    endtask

    task automatic expect_q(input string tag, input logic [31:0] got [$],
                            input logic [31:0] want [$]);
        bit ok;
        ok = (got.size() == want.size());
        if (ok) foreach (want[i]) if (got[i] !== want[i]) ok = 1'b0;
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s got=%p want=%p", tag, got, want);
        end
    endtask

    initial begin
        sel = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        r0_addr = '0; r1_addr = '0;
        r0_len = '0; r1_len = '0;
        ptr_m[0] = 1'b0; ptr_m[1] = 1'b0;
        drop0 = 1'b0; drop1 = 1'b0;
        #2 rst_n = 1'b0;
        run(2);
        total++;
        assert (if1.bram_addrb === '0) else begin
            bad++; $error("FAIL reset_addrb1 got=%h want=0", if1.bram_addrb);
        end
        total++;
        assert (if3.bram_addrb === '0) else begin
            bad++; $error("FAIL reset_addrb3 got=%h want=0", if3.bram_addrb);
        end
        rst_n = 1'b1;
        run(2);

        // Lone r0, aligned, 4 beats, latency 1
        addr_log.delete(); rv_count = 0;
        r0_addr = 32'h10; r0_len = 4'd3; r0_req = 1'b1;
        run(8);
        want_q = {32'h10, 32'h18, 32'h20, 32'h28};
        expect_q("burst_addrs", addr_log, want_q);
        total++;
        assert (rv_count === 4) else begin
            bad++; $error("FAIL burst_beats got=%0d want=4", rv_count);
        end

        // Dual single-beat requests after reset alternate starting with r0
        pulse_reset();
        gnt_log.delete();
        for (int round = 0; round < 3; round++) begin
            r0_addr = 32'h40; r1_addr = 32'h80; r0_len = 4'd0; r1_len = 4'd0;
            r0_req = 1'b1; r1_req = 1'b1;
            run(8);
        end
        want_q = {32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1};
        expect_q("rr_order", gnt_log, want_q);

        // Address wrap at the top of the space
        addr_log.delete();
        r1_addr = 32'hFFFF_FFF8; r1_len = 4'd1; r1_req = 1'b1;
        run(6);
        want_q = {32'hFFFF_FFF8, 32'h0};
        expect_q("wrap_addrs", addr_log, want_q);

        // Unaligned start is rounded down to the beat
        addr_log.delete();
        r0_addr = 32'h0F; r0_len = 4'd1; r0_req = 1'b1;
        run(6);
        want_q = {32'h08, 32'h10};
        expect_q("align_addrs", addr_log, want_q);

        // Latency-3 instance, 16-beat burst
        sel = 1'b1;
        rv_count = 0;
        r0_addr = 32'h1000; r0_len = 4'd15; r0_req = 1'b1;
        run(24);
        total++;
        assert (rv_count === 16) else begin
            bad++; $error("FAIL long_beats got=%0d want=16", rv_count);
        end

        // Reset during beat 2 of an 8-beat burst (pointer was 1 from the last r0 burst)
        sel = 1'b0;
        r0_addr = 32'h100; r0_len = 4'd7; r0_req = 1'b1;
        run(3);
        pulse_reset();
        rv_count = 0;
        run(4);
        total++;
        assert (rv_count === 0) else begin
            bad++; $error("FAIL stale_rvalid got=%0d want=0", rv_count);
        end
        gnt_log.delete();
        r0_addr = 32'h300; r1_addr = 32'h200; r0_len = 4'd0; r1_len = 4'd2;
        r0_req = 1'b1; r1_req = 1'b1;
        run(12);
        r1_req = 1'b1;
        run(8);
        want_q = {32'd0, 32'd1, 32'd1};
        expect_q("post_reset_gnt", gnt_log, want_q);

        // Random traffic on both instances
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 200; i++) begin
                if (!r0_req && $urandom_range(3) == 0) begin
                    r0_addr = $urandom; r0_len = 4'($urandom_range(15)); r0_req = 1'b1;
                end
                if (!r1_req && $urandom_range(3) == 0) begin
                    r1_addr = $urandom; r1_len = 4'($urandom_range(15)); r1_req = 1'b1;
                end
                step();
            end
            run(60);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
